lcd_spi_rx: RTL

LCD_SPI_RX -- requirements
Module: lcd_spi_rx

---
 rtl/lcd_spi_rx_if.sv | 17 +
 rtl/lcd_spi_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_rx_if.sv
// Pixel-write and command-strobe bus driven by the SPI LCD receiver.
interface lcd_spi_rx_if #(
   parameter int c_x_bits     = 8,
   parameter int c_y_bits     = 8,
   parameter int c_color_bits = 16
);
   logic                    fb_we;
   logic [c_x_bits-1:0]     fb_x;
   logic [c_y_bits-1:0]     fb_y;
   logic [c_color_bits-1:0] fb_data;
   logic                    cmd_valid;
   logic [7:0]              cmd_byte;
   logic                    frame_done;

   modport master (output fb_we, fb_x, fb_y, fb_data, cmd_valid, cmd_byte, frame_done);
   modport slave  (input  fb_we, fb_x, fb_y, fb_data, cmd_valid, cmd_byte, frame_done);
endinterface

// File: rtl/lcd_spi_rx.sv
// SPI LCD controller receiver: oversamples the SPI lines on clk_pixel, decodes
// CASET/RASET/RAMWR and turns pixel data into framebuffer write strobes.
module lcd_spi_rx #(
   parameter int c_x_size        = 240,
   parameter int c_y_size        = 240,
   parameter int c_x_bits        = $clog2(c_x_size),
   parameter int c_y_bits        = $clog2(c_y_size),
   parameter int c_color_bits    = 16,
   parameter int c_sample_rising = 1
) (
   input  logic clk_pixel,
   input  logic reset,
   input  logic spi_csn,
   input  logic spi_clk,
   input  logic spi_mosi,
   input  logic spi_dc,
   input  logic spi_resn,
   lcd_spi_rx_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_SKIP} state_t;

   localparam logic [c_x_bits-1:0] c_x_last = c_x_bits'(c_x_size - 1);
   localparam logic [c_y_bits-1:0] c_y_last = c_y_bits'(c_y_size - 1);
   localparam logic [c_x_bits-1:0] c_x_one  = 1;
   localparam logic [c_y_bits-1:0] c_y_one  = 1;
   // sync vector order: {resn, dc, mosi, csn, clk}; csn idles deselected, resn asserted
   localparam logic [4:0] c_sync_rst = 5'b00010;

   logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic       clk_prev_q, clk_prev_d;
   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [1:0] argcnt_q, argcnt_d;
   logic [23:0] arg_q, arg_d;
   logic [c_x_bits-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d, fb_x_q, fb_x_d;
   logic [c_y_bits-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d, fb_y_q, fb_y_d;
   logic       phase_q, phase_d;
   logic [7:0] hi_q, hi_d, cmd_byte_q, cmd_byte_d;
   logic [c_color_bits-1:0] fb_data_q, fb_data_d;
   logic       fb_we_q, fb_we_d, cmd_valid_q, cmd_valid_d, frame_done_q, frame_done_d;

   logic s_clk, s_csn, s_mosi, s_dc, s_resn, rst_all, sample, byte_stb;
   logic [7:0]  rx_byte;
   logic [15:0] win_s, win_e, pix16;
   logic [c_x_bits-1:0] new_xs, new_xe_raw;
   logic [c_y_bits-1:0] new_ys, new_ye_raw;

   assign s_clk   = sync2_q[0];
   assign s_csn   = sync2_q[1];
   assign s_mosi  = sync2_q[2];
   assign s_dc    = sync2_q[3];
   assign s_resn  = sync2_q[4];
   assign rst_all = reset | ~s_resn;
   assign sample  = (s_clk != clk_prev_q) && (s_clk == (c_sample_rising != 0)) && !s_csn;
   assign byte_stb = sample && (cnt_q == 3'd7);
   assign rx_byte = {shift_q, s_mosi};
   // window arguments: first two bytes start, last two end (big endian)
   assign win_s      = arg_q[23:8];
   assign win_e      = {arg_q[7:0], rx_byte};
   assign new_xs     = win_s[c_x_bits-1:0];
   assign new_xe_raw = win_e[c_x_bits-1:0];
   assign new_ys     = win_s[c_y_bits-1:0];
   assign new_ye_raw = win_e[c_y_bits-1:0];
   assign pix16      = {hi_q, rx_byte};

   // two-stage synchronizer plus the previous-clock stage for edge detection
   always_comb begin
      sync1_d    = {spi_resn, spi_dc, spi_mosi, spi_csn, spi_clk};
      sync2_d    = sync1_q;
      clk_prev_d = s_clk;
   end

   // synchronizer registers, cleared only by the system reset
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         sync1_q    <= c_sync_rst;
         sync2_q    <= c_sync_rst;
         clk_prev_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         clk_prev_q <= clk_prev_d;
      end
   end

   // state register
   always_ff @(posedge clk_pixel) state_q <= state_d;

   // next state: commands always redirect, window setup ends after 4 data bytes
   always_comb begin
      state_d = state_q;
      if (byte_stb && !s_dc) begin
         case (rx_byte)
            8'h2A:   state_d = S_CASET;
            8'h2B:   state_d = S_RASET;
            8'h2C:   state_d = S_RAMWR;
            default: state_d = S_SKIP;
         endcase
      end else if (byte_stb && (state_q == S_CASET || state_q == S_RASET) && argcnt_q == 2'd3) begin
         state_d = S_SKIP;
      end
      if (rst_all) state_d = S_IDLE;
   end

   // byte assembly, window registers, pixel cursor and output strobes
   always_comb begin
      cnt_d = cnt_q;  shift_d = shift_q;  argcnt_d = argcnt_q;  arg_d = arg_q;
      xs_d = xs_q;  xe_d = xe_q;  ys_d = ys_q;  ye_d = ye_q;  x_d = x_q;  y_d = y_q;
      phase_d = phase_q;  hi_d = hi_q;
      fb_x_d = fb_x_q;  fb_y_d = fb_y_q;  fb_data_d = fb_data_q;  cmd_byte_d = cmd_byte_q;
      fb_we_d = 1'b0;  cmd_valid_d = 1'b0;  frame_done_d = 1'b0;

      if (s_csn) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (sample) begin
         cnt_d   = cnt_q + 3'd1;
         shift_d = {shift_q[5:0], s_mosi};
      end

      if (byte_stb) begin
         if (!s_dc) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rx_byte;
            argcnt_d    = '0;
            phase_d     = 1'b0;
            if (rx_byte == 8'h2C) begin
               x_d = xs_q;
               y_d = ys_q;
            end
         end else begin
            case (state_q)
               S_CASET, S_RASET: begin
                  arg_d    = {arg_q[15:0], rx_byte};
                  argcnt_d = argcnt_q + 2'd1;
                  if (argcnt_q == 2'd3) begin
                     if (state_q == S_CASET) begin
                        xs_d = new_xs;
                        xe_d = (new_xe_raw < new_xs) ? new_xs : new_xe_raw;
                     end else begin
                        ys_d = new_ys;
                        ye_d = (new_ye_raw < new_ys) ? new_ys : new_ye_raw;
                     end
                  end
               end
               S_RAMWR: begin
                  if (c_color_bits == 16 && !phase_q) begin
                     hi_d    = rx_byte;
                     phase_d = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     fb_we_d   = 1'b1;
                     fb_x_d    = x_q;
                     fb_y_d    = y_q;
                     fb_data_d = pix16[c_color_bits-1:0];
                     if (x_q != xe_q) begin
                        x_d = x_q + c_x_one;
                     end else begin
                        x_d = xs_q;
                        if (y_q != ye_q) begin
                           y_d = y_q + c_y_one;
                        end else begin
                           y_d          = ys_q;
                           frame_done_d = 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      if (rst_all) begin
         cnt_d = '0;  shift_d = '0;  argcnt_d = '0;  arg_d = '0;
         xs_d = '0;  xe_d = c_x_last;  ys_d = '0;  ye_d = c_y_last;  x_d = '0;  y_d = '0;
         phase_d = 1'b0;  hi_d = '0;
         fb_x_d = '0;  fb_y_d = '0;  fb_data_d = '0;  cmd_byte_d = '0;
         fb_we_d = 1'b0;  cmd_valid_d = 1'b0;  frame_done_d = 1'b0;
      end
   end

   // datapath registers (reset folded into the _d logic above)
   always_ff @(posedge clk_pixel) begin
      cnt_q <= cnt_d;  shift_q <= shift_d;  argcnt_q <= argcnt_d;  arg_q <= arg_d;
      xs_q <= xs_d;  xe_q <= xe_d;  ys_q <= ys_d;  ye_q <= ye_d;  x_q <= x_d;  y_q <= y_d;
      phase_q <= phase_d;  hi_q <= hi_d;
      fb_x_q <= fb_x_d;  fb_y_q <= fb_y_d;  fb_data_q <= fb_data_d;  cmd_byte_q <= cmd_byte_d;
      fb_we_q <= fb_we_d;  cmd_valid_q <= cmd_valid_d;  frame_done_q <= frame_done_d;
   end

   assign bus.fb_we      = fb_we_q;
   assign bus.fb_x       = fb_x_q;
   assign bus.fb_y       = fb_y_q;
   assign bus.fb_data    = fb_data_q;
   assign bus.cmd_valid  = cmd_valid_q;
   assign bus.cmd_byte   = cmd_byte_q;
   assign bus.frame_done = frame_done_q;
endmodule
